// File: rtl/ctr_pkg.sv
// Shared constants, FSM state type and length helpers for the CTR XOR stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ctr_pkg;

  localparam int BLK_W   = 128;
  localparam int MAX_BLK = 8;
  localparam int LEN_W   = 11;
  localparam int MAX_LEN = MAX_BLK * BLK_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctr_state_e;

  // Number of 128-bit blocks covering len bits (ceiling division).
  function automatic logic [3:0] calc_nblk(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] tmp;
    tmp = {1'b0, len} + (LEN_W+1)'(BLK_W - 1);
    return tmp[10:7];
  endfunction

  // Valid bits in the final block, 1..128.
  function automatic logic [7:0] calc_rlast(input logic [LEN_W-1:0] len);
    return (len[6:0] == 7'd0) ? 8'd128 : {1'b0, len[6:0]};
  endfunction

  // Keeps the top r bits (the first r message bits), clears the rest.
  function automatic logic [BLK_W-1:0] last_mask(input logic [7:0] r);
    return ~({BLK_W{1'b1}} >> r);
  endfunction

endpackage

// File: rtl/ctr_ks_fifo.sv
// Two-entry keystream buffer; head is visible combinationally while non-empty.
// Latency: 1 cycle push-to-head; simultaneous push and pop keeps occupancy.
// Backpressure: full flag must gate push; empty flag must gate pop.
module ctr_ks_fifo
  import ctr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [BLK_W-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [BLK_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [BLK_W-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and occupancy tracking; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ctr_xor_stage.sv
// CTR-mode combiner: XORs buffered keystream with plaintext, masks the tail of the last block.
// Latency: 1 cycle from join (keystream head + plaintext) to registered ciphertext.
// Backpressure: ct_ready stall holds the output register and drops pt_ready; ks_ready drops when buffer full or all blocks fetched.
module ctr_xor_stage
  import ctr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ks_valid,
  output logic             ks_ready,
  input  logic [BLK_W-1:0] ks_data,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [BLK_W-1:0] pt_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [BLK_W-1:0] ct_data,
  output logic             ct_last,
  output logic             busy,
  output logic             done
);

  ctr_state_e       state_q, state_d;
  logic [3:0]       nblk_q;
  logic [7:0]       rlast_q;
  logic [3:0]       ks_cnt_q;
  logic [3:0]       blk_cnt_q;
  logic             ct_valid_q;
  logic             ct_last_q;
  logic [BLK_W-1:0] ct_data_q;

  logic             start_ok;
  logic             run;
  logic             out_free;
  logic             join_fire;
  logic             push;
  logic             is_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic [BLK_W-1:0] ks_head;
  logic [BLK_W-1:0] ct_next;

  assign start_ok  = start && (msg_len != '0) && (msg_len <= LEN_W'(MAX_LEN));
  assign run       = (state_q == RUN);
  assign out_free  = !ct_valid_q || ct_ready;
  assign ks_ready  = run && !fifo_full && (ks_cnt_q < nblk_q);
  assign pt_ready  = run && !fifo_empty && out_free;
  assign join_fire = pt_ready && pt_valid;
  assign push      = ks_valid && ks_ready;
  assign is_last   = (blk_cnt_q == 4'(nblk_q - 4'd1));

  assign ct_valid = ct_valid_q;
  assign ct_last  = ct_last_q;
  assign ct_data  = ct_data_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  ctr_ks_fifo u_ks_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (ks_data),
    .pop_i      (join_fire),
    .head_o     (ks_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Combine keystream and plaintext; only the final block gets its tail cleared.
  always_comb begin
    ct_next = ks_head ^ pt_data;
    if (is_last) ct_next = ct_next & last_mask(rlast_q);
  end

  // Next-state: message accepted, last block handed off, one-cycle completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (ct_valid_q && ct_ready && ct_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, message geometry, block counters and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      nblk_q     <= 4'd0;
      rlast_q    <= 8'd0;
      ks_cnt_q   <= 4'd0;
      blk_cnt_q  <= 4'd0;
      ct_valid_q <= 1'b0;
      ct_last_q  <= 1'b0;
      ct_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_ok) begin
        nblk_q    <= calc_nblk(msg_len);
        rlast_q   <= calc_rlast(msg_len);
        ks_cnt_q  <= 4'd0;
        blk_cnt_q <= 4'd0;
      end
      if (push) ks_cnt_q <= ks_cnt_q + 4'd1;
      if (join_fire) begin
        blk_cnt_q  <= blk_cnt_q + 4'd1;
        ct_valid_q <= 1'b1;
        ct_data_q  <= ct_next;
        ct_last_q  <= is_last;
      end else if (ct_ready) begin
        ct_valid_q <= 1'b0;
        ct_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctr_xor_stage.sv
// Bench for ctr_xor_stage: directed scenarios plus randomized messages against a block-level model.
// Latency: n/a.
// Backpressure: randomized valid/ready on all three streams.
module tb_ctr_xor_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [10:0]  msg_len = '0;
  logic         ks_valid = 1'b0;
  logic         ks_ready;
  logic [127:0] ks_data = '0;
  logic         pt_valid = 1'b0;
  logic         pt_ready;
  logic [127:0] pt_data = '0;
  logic         ct_valid;
  logic         ct_ready = 1'b0;
  logic [127:0] ct_data;
  logic         ct_last;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] ks_a [8];
  logic [127:0] pt_a [8];
  logic [127:0] last_ct;

  always #5 clk = ~clk;

  ctr_xor_stage dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .msg_len  (msg_len),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .ks_data  (ks_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_data  (pt_data),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct_data  (ct_data),
    .ct_last  (ct_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      ks_a[i] = rnd128();
      pt_a[i] = rnd128();
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; ks_valid = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0;
  endtask

  // Called at a negedge; applies one cycle of reset and returns at the next negedge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one message from a negedge. Model: block i = ks[i]^pt[i]; final block keeps only
  // its first r message bits (MSB first). stall_blk holds ct_ready low 3 cycles on that block,
  // abort_at returns early after that many outputs, glitch issues a stray start mid-message.
  task automatic run_msg(input int len, input int vpct, input int rpct,
                         input int stall_blk, input int abort_at, input bit glitch);
    int nblk, r, ki, pi, oi, cyc, stall_n;
    logic [127:0] expv [8];
    bit           prev_hold;
    logic [127:0] prev_dat;
    logic         prev_last;
    nblk = (len + 127) / 128;
    r    = len - 128 * (nblk - 1);
    for (int i = 0; i < 8; i++) expv[i] = ks_a[i] ^ pt_a[i];
    for (int b = 0; b < 128; b++)
      if ((127 - b) >= r) expv[nblk-1][b] = 1'b0;
    ki = 0; pi = 0; oi = 0; cyc = 0; stall_n = 0; prev_hold = 0;
    prev_dat = '0; prev_last = 1'b0;

    start = 1'b1; msg_len = 11'(len);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);

    while (oi < nblk && cyc < 3000) begin
      ks_valid = (ki < nblk) ? ($urandom_range(99) < vpct) : 1'b1;
      ks_data  = (ki < nblk) ? ks_a[ki] : rnd128();
      pt_valid = (pi < nblk) && ($urandom_range(99) < vpct);
      pt_data  = (pi < nblk) ? pt_a[pi] : rnd128();
      ct_ready = ($urandom_range(99) < rpct);
      start    = glitch && (cyc == 3);
      if (glitch) msg_len = 11'd128;
      #1;
      if (stall_blk == oi && ct_valid && stall_n < 3) begin
        ct_ready = 1'b0;
        stall_n++;
        #1;
        chk("pt_ready_in_stall", pt_ready, 1'b0);
      end
      if (prev_hold) begin
        chk("hold_valid", ct_valid, 1'b1);
        chk("hold_data", ct_data, prev_dat);
        chk("hold_last", ct_last, prev_last);
      end
      if (ki >= nblk) chk("no_extra_ks", ks_ready, 1'b0);
      if (glitch && cyc == 3) chk("busy_glitch", busy, 1'b1);
      if (ct_valid && ct_ready) begin
        chk($sformatf("ct_data_b%0d", oi), ct_data, expv[oi]);
        chk($sformatf("ct_last_b%0d", oi), ct_last, (oi == nblk - 1));
        last_ct = ct_data;
        oi++;
      end
      prev_hold = ct_valid && !ct_ready;
      prev_dat  = ct_data;
      prev_last = ct_last;
      if (ks_valid && ks_ready) ki++;
      if (pt_valid && pt_ready) pi++;
      if (abort_at != 0 && oi == abort_at) return;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 3000) chk("msg_timeout", 1'b1, 1'b0);
    idle_inputs();
    #1;
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b1);
    chk("ct_valid_in_done", ct_valid, 1'b0);
    chk("pt_ready_in_done", pt_ready, 1'b0);
    @(negedge clk);
    chk("done_cleared", done, 1'b0);
    chk("busy_cleared", busy, 1'b0);
  endtask

  initial begin
    int acc;
    last_ct = '0;
    for (int i = 0; i < 8; i++) begin ks_a[i] = '0; pt_a[i] = '0; end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ct_valid", ct_valid, 1'b0);
    chk("rst_ct_data", ct_data, '0);
    chk("rst_ct_last", ct_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ks_ready", ks_ready, 1'b0);
    chk("rst_pt_ready", pt_ready, 1'b0);

    // Single full block with known answer
    ks_a[0] = {128{1'b1}};
    pt_a[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    run_msg(128, 100, 100, -1, 0, 0);
    chk("kat_128", last_ct, 128'hFEDCBA9876543210FEDCBA9876543210);

    // Eight blocks with a 3-cycle output stall on block 2
    fill_random();
    run_msg(1024, 100, 100, 1, 0, 0);

    // 200-bit message: partial last block
    for (int i = 0; i < 8; i++) begin ks_a[i] = {128{1'b1}}; pt_a[i] = '0; end
    run_msg(200, 100, 100, -1, 0, 0);
    chk("tail_200", last_ct, {{72{1'b1}}, {56{1'b0}}});

    // Keystream offered early without plaintext: buffer fills to two
    start = 1'b1; msg_len = 11'd512;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    ks_valid = 1'b1; pt_valid = 1'b0; ct_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ks_data = rnd128();
      #1;
      if (ks_valid && ks_ready) acc++;
      @(negedge clk);
    end
    chk("ks_early_count", 32'(acc), 32'd2);
    chk("ks_ready_full", ks_ready, 1'b0);
    pt_valid = 1'b1;
    #1;
    chk("pt_ready_join", pt_ready, 1'b1);
    @(negedge clk);
    do_reset();

    // Reset mid-message, then immediate new start
    fill_random();
    run_msg(1024, 100, 100, -1, 3, 0);
    do_reset();
    chk("abort_ct_valid", ct_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    fill_random();
    run_msg(128, 100, 100, -1, 0, 0);

    // Illegal starts are ignored
    start = 1'b1; msg_len = 11'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_ignored", busy, 1'b0);
    chk("len0_ks_ready", ks_ready, 1'b0);
    start = 1'b1; msg_len = 11'd1025;
    @(negedge clk);
    start = 1'b0;
    chk("len1025_ignored", busy, 1'b0);
    fill_random();
    run_msg(640, 80, 80, -1, 0, 1);

    // Randomized messages with random backpressure
    for (int m = 0; m < 14; m++) begin
      fill_random();
      run_msg($urandom_range(1, 1024), $urandom_range(30, 100), $urandom_range(30, 100), -1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctr_xor_stage.md
CTR_XOR_STAGE -- requirements
Module: ctr_xor_stage

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle pulse; begins a message; msg_len is sampled on this cycle.
REQ-005 msg_len  in  11  message length in bits; legal range 1..1024.
REQ-006 ks_valid / ks_ready / ks_data  in / out / in  1 / 1 / 128  keystream blocks, E(K, IV+i), from the AES-256 core.
REQ-007 pt_valid / pt_ready / pt_data  in / out / in  1 / 1 / 128  plaintext blocks, first block first; bit 127 is the first message bit.
REQ-008 ct_valid / ct_ready / ct_data / ct_last  out / in / out / out  1 / 1 / 128 / 1  ciphertext block stream.
REQ-009 busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-010 done  out  1  one-cycle pulse on message completion.

Function
REQ-011 Block count: nblk = (msg_len+127)>>7, 4 bits, range 1..8.
- Last-block valid bits: r = msg_len - 128*(nblk-1), range 1..128.
REQ-012 FSM states:
- IDLE -> RUN on start with 1 <= msg_len <= 1024.
- RUN -> DONE on the output handshake (ct_valid and ct_ready) of the block with ct_last=1.
- DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-013 start is ignored when msg_len=0, when msg_len>1024, and in any state other than IDLE.
REQ-014 Keystream is buffered in a 2-entry FIFO.
- ks_ready = RUN and FIFO not full and ks_cnt<nblk.
- ks_cnt counts accepted keystream blocks, so no keystream beyond nblk is consumed.
REQ-015 Output register:
- Join fires when FIFO non-empty, pt_valid=1, and (ct_valid=0 or ct_ready=1).
- pt_ready = RUN and FIFO non-empty and (ct_valid=0 or ct_ready=1).
REQ-016 On a join, the registered output takes ct_data = ks_head ^ pt_data on the next edge; latency is 1 cycle. The FIFO pops and blk_cnt increments on the same edge.
REQ-017 ct_last = 1 when the registered block is block nblk-1. For that block, ct_data bits [127-r:0] are forced to 0 when r<128.
REQ-018 ct_valid, once high, holds ct_data and ct_last stable until ct_ready=1. Back-to-back joins sustain 1 block per cycle when ct_ready=1.
REQ-019 A FIFO push and pop in the same cycle is legal; occupancy is unchanged.
REQ-020 No XOR, FIFO or counter activity occurs in IDLE or DONE; pt_ready=ks_ready=0 in those states.

Reset
REQ-021 While rst=1, on each clk edge:
- state <= IDLE.
- ct_valid, ct_last, busy, done <= 0.
- ct_data <= 0.
- FIFO flushed; ks_cnt and blk_cnt <= 0.
REQ-022 Reset asserted mid-message discards all buffered keystream and any pending output. The first cycle after rst deasserts accepts a new start.

Structure
REQ-023 Package ctr_pkg holds:
- BLK_W=128, MAX_BLK=8, LEN_W=11.
- The FSM state enum (IDLE, RUN, DONE).
- The last-block mask function.
REQ-024 One sub-module, ctr_ks_fifo: 2-entry, 128-bit, with push/pop/full/empty, synchronous rst.

Verification
REQ-025 msg_len=128, ks=all-ones, pt=0x0123456789ABCDEF0123456789ABCDEF -> one block, ct_data=0xFEDCBA9876543210FEDCBA9876543210, ct_last=1; done pulses 1 cycle after the handshake.
REQ-026 msg_len=1024, 8 blocks, ct_ready held low 3 cycles after block 2 -> block 2 stable, pt_ready=0 during the stall, all 8 blocks correct, ct_last only on block 8.
REQ-027 msg_len=200, ks=all-ones, pt=all-zero -> block 1 = all-ones; block 2 upper 72 bits ones, lower 56 bits zero.
REQ-028 Keystream offered early with ks_valid held high, no plaintext -> exactly 2 keystream blocks accepted, then ks_ready=0 until the first join.
REQ-029 rst for 1 cycle after 3 of 8 blocks -> next cycle ct_valid=0, busy=0; a new start with msg_len=128 completes correctly.
REQ-030 Start with msg_len=0, start with msg_len=1025, and start while busy=1 -> all ignored, no change to busy, state or counters.
